// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage MIPS pipeline.
// Handles the post-reset drain, load-use stalls, taken branches resolved in MEM
// and a multi-cycle data memory guarded by a watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter ports read constant zero.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,   // 1..15
    parameter int unsigned MEM_TIMEOUT  = 16   // 2..255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_ifid_rs,
    input  logic [4:0]  i_ifid_rt,
    input  logic        i_ifid_uses_rt,
    input  logic        i_idex_memread,
    input  logic [4:0]  i_idex_wreg,
    input  logic        i_exmem_branch,
    input  logic        i_exmem_zero,
    input  logic        i_exmem_memread,
    input  logic        i_exmem_memwrite,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_ifid_write,
    output logic        o_idex_write,
    output logic        o_exmem_write,
    output logic        o_pc_src,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic        o_flush_exmem,
    output logic        o_bubble_memwb,
    output logic        o_mem_err,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_memwait_cnt
);

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    logic [3:0] r_drain_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    logic w_mem_busy;
    logic w_branch;
    logic w_load_use;
    logic w_drain_out;   // drain outputs (reset or DRAIN state)
    logic w_freeze;      // whole pipeline held, MEM/WB bubbled
    logic w_resolve;     // normal RUN priority evaluation applies
    logic w_timeout;     // watchdog drops the pending access this cycle
    logic w_do_branch;
    logic w_do_lu;

    assign w_mem_busy = (i_exmem_memread | i_exmem_memwrite) & ~i_mem_ready;
    assign w_branch   = i_exmem_branch & i_exmem_zero;
    assign w_load_use = i_idex_memread & (i_idex_wreg != 5'd0) &
                        ((i_idex_wreg == i_ifid_rs) |
                         (i_ifid_uses_rt & (i_idex_wreg == i_ifid_rt)));

    // Classify the current cycle from state and inputs (Mealy decision).
    always_comb begin
        w_drain_out = 1'b0;
        w_freeze    = 1'b0;
        w_resolve   = 1'b0;
        w_timeout   = 1'b0;
        if (i_rst) begin
            w_drain_out = 1'b1;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    w_drain_out = 1'b1;
                end
                ST_RUN: begin
                    if (w_mem_busy) begin
                        w_freeze = 1'b1;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        w_resolve = 1'b1;
                    end else if (r_wait_cnt < WAIT_LIMIT) begin
                        w_freeze = 1'b1;
                    end else begin
                        // Watchdog: give up on the access, let the pipe move on.
                        w_resolve = 1'b1;
                        w_timeout = 1'b1;
                    end
                end
                default: begin
                    w_drain_out = 1'b1;
                end
            endcase
        end
    end

    // A taken branch wins over load-use; both only act when the memory is not holding us.
    assign w_do_branch = w_resolve & w_branch;
    assign w_do_lu     = w_resolve & ~w_branch & w_load_use;

    assign o_pc_write     = w_resolve & ~w_do_lu;
    assign o_ifid_write   = w_resolve & ~w_do_lu;
    assign o_idex_write   = w_resolve;
    assign o_exmem_write  = w_resolve;
    assign o_pc_src       = w_do_branch;
    assign o_flush_ifid   = w_drain_out | w_do_branch;
    assign o_flush_idex   = w_drain_out | w_do_branch | w_do_lu;
    assign o_flush_exmem  = w_drain_out | w_do_branch;
    assign o_bubble_memwb = w_drain_out | w_freeze | w_timeout;
    assign o_mem_err      = r_mem_err;

    // Controller FSM: drain sequencing, memory-wait tracking and sticky watchdog error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 4'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_freeze) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                        r_mem_err  <= r_mem_err | w_timeout;
                    end
                end
                default: begin
                    r_state <= ST_DRAIN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_memwait_cnt;

    // Performance counters; free-running wrap, idle during reset and drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt   <= 32'd0;
            r_flush_cnt   <= 32'd0;
            r_memwait_cnt <= 32'd0;
        end else begin
            if (w_freeze | w_do_lu) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_do_branch) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (r_state == ST_MEM_WAIT) begin
                r_memwait_cnt <= r_memwait_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_memwait_cnt = r_memwait_cnt;
`else
    assign o_stall_cnt   = 32'd0;
    assign o_flush_cnt   = 32'd0;
    assign o_memwait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ifid_rs, ifid_rt, idex_wreg;
    logic        ifid_uses_rt, idex_memread;
    logic        exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, mem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write, pc_src;
    logic        flush_ifid, flush_idex, flush_exmem, bubble_memwb, mem_err;
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: cycles of drain left, pending access age, sticky error, counters.
    int          m_drain_left = 0;
    bit          m_waiting    = 1'b0;
    int          m_age        = 0;
    bit          m_err        = 1'b0;
    logic [31:0] m_stall      = 32'd0;
    logic [31:0] m_flush      = 32'd0;
    logic [31:0] m_memwait    = 32'd0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt), .i_ifid_uses_rt(ifid_uses_rt),
        .i_idex_memread(idex_memread), .i_idex_wreg(idex_wreg),
        .i_exmem_branch(exmem_branch), .i_exmem_zero(exmem_zero),
        .i_exmem_memread(exmem_memread), .i_exmem_memwrite(exmem_memwrite),
        .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_idex_write(idex_write),
        .o_exmem_write(exmem_write), .o_pc_src(pc_src),
        .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex), .o_flush_exmem(flush_exmem),
        .o_bubble_memwb(bubble_memwb), .o_mem_err(mem_err),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_quiet();
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        idex_memread = 1'b0; idex_wreg = 5'd0;
        exmem_branch = 1'b0; exmem_zero = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; mem_ready = 1'b0;
    endtask

    // Compare outputs with the model for the current inputs, then advance the model.
    task automatic check_cycle(input string tag);
        bit drain, freeze, tmo, br, lu, busy;
        logic [8:0] exp_ctl;
        logic [8:0] obs_ctl;
        drain = 1'b0; freeze = 1'b0; tmo = 1'b0;
        busy = (exmem_memread || exmem_memwrite) && !mem_ready;
        br   = exmem_branch && exmem_zero;
        lu   = idex_memread && (idex_wreg != 5'd0) &&
               ((idex_wreg == ifid_rs) || (ifid_uses_rt && (idex_wreg == ifid_rt)));
        if (rst || m_drain_left > 0) drain = 1'b1;
        else if (!m_waiting) freeze = busy;
        else if (!mem_ready && m_age < TMO) freeze = 1'b1;
        else tmo = !mem_ready;

        // {pc_write, ifid_write, idex_write, exmem_write, pc_src, fl_ifid, fl_idex, fl_exmem, bubble}
        if (drain)       exp_ctl = 9'b0000_0111_1;
        else if (freeze) exp_ctl = 9'b0000_0000_1;
        else if (br)     exp_ctl = {8'b1111_1111, tmo};
        else if (lu)     exp_ctl = {8'b0011_0010, tmo};
        else             exp_ctl = {8'b1111_0000, tmo};
        obs_ctl = {pc_write, ifid_write, idex_write, exmem_write, pc_src,
                   flush_ifid, flush_idex, flush_exmem, bubble_memwb};
        chk({tag, ".ctl"}, 32'(obs_ctl), 32'(exp_ctl));
        chk({tag, ".mem_err"}, 32'(mem_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
        chk({tag, ".memwait_cnt"}, memwait_cnt, m_memwait);
`else
        chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
        chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
        chk({tag, ".memwait_cnt"}, memwait_cnt, 32'd0);
`endif

        if (rst) begin
            m_drain_left = DRAIN; m_waiting = 1'b0; m_age = 0; m_err = 1'b0;
            m_stall = 32'd0; m_flush = 32'd0; m_memwait = 32'd0;
        end else if (drain) begin
            m_drain_left--;
        end else if (freeze) begin
            m_stall++;
            if (m_waiting) begin
                m_memwait++;
                m_age++;
            end else begin
                m_waiting = 1'b1;
                m_age = 1;
            end
        end else begin
            if (m_waiting) m_memwait++;
            if (tmo) m_err = 1'b1;
            m_waiting = 1'b0;
            if (br) m_flush++;
            else if (lu) m_stall++;
        end
    endtask

    // Inputs are already set (just after an edge); check, then cross one clock edge.
    task automatic cycle(input string tag);
        #1;
        check_cycle(tag);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int thr;
        rst = 1'b1;
        set_quiet();
        @(posedge clk);
        #1;

        // Reset held, then drain after release.
        repeat (2) cycle("reset");
        rst = 1'b0;
        for (int i = 0; i < DRAIN; i++) cycle("drain");
        cycle("run_idle");
        chk("run_pc_write", 32'(pc_write), 32'd1);
        repeat (2) cycle("run_idle");

        // Load-use on rs: one stall, then the load has advanced.
        idex_memread = 1'b1; idex_wreg = 5'd8; ifid_rs = 5'd8;
        cycle("loaduse_rs");
        idex_memread = 1'b0;
        cycle("loaduse_clear");
        // Load-use on rt, and a rt match that does not count.
        idex_memread = 1'b1; idex_wreg = 5'd9; ifid_rs = 5'd1; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
        cycle("loaduse_rt");
        ifid_uses_rt = 1'b0;
        cycle("loaduse_rt_unused");
        // Destination $zero never stalls.
        idex_wreg = 5'd0; ifid_rs = 5'd0;
        cycle("loaduse_r0");
        set_quiet();

        // Branch taken with a simultaneous load-use.
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        idex_memread = 1'b1; idex_wreg = 5'd5; ifid_rs = 5'd5;
        cycle("branch_lu");
        exmem_zero = 1'b0;
        cycle("branch_not_taken");
        set_quiet();

        // Memory access with 3 wait cycles, ready on the 4th.
        exmem_memread = 1'b1; mem_ready = 1'b0;
        repeat (3) cycle("memwait");
        mem_ready = 1'b1;
        cycle("memwait_release");
        // Zero-wait access.
        cycle("mem_zero_wait");
        set_quiet();
        cycle("idle");

        // Watchdog: write never acknowledged.
        exmem_memwrite = 1'b1; mem_ready = 1'b0;
        repeat (TMO + 1) cycle("watchdog");
        exmem_memwrite = 1'b0;
        repeat (3) cycle("post_watchdog");
        chk("watchdog_sticky", 32'(mem_err), 32'd1);

        // Counter wrap on the flush counter.
`ifdef HAZARD_PERF_CNT_EN
        force dut.r_flush_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_flush_cnt;
        m_flush = 32'hFFFF_FFFF;
`endif
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        cycle("wrap_branch");
        set_quiet();
        cycle("wrap_after");

        // Reset clears the sticky error and restarts the drain.
        rst = 1'b1;
        cycle("rerst");
        rst = 1'b0;
        repeat (DRAIN + 1) cycle("redrain");
        chk("rerst_mem_err", 32'(mem_err), 32'd0);

        // Randomized traffic with varying memory readiness.
        for (int blk = 0; blk < 6; blk++) begin
            thr = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 5 : 9);
            for (int i = 0; i < 120; i++) begin
                rst            = ($urandom_range(0, 199) == 0);
                ifid_rs        = 5'($urandom_range(0, 3));
                ifid_rt        = 5'($urandom_range(0, 3));
                ifid_uses_rt   = 1'($urandom_range(0, 1));
                idex_memread   = ($urandom_range(0, 2) == 0);
                idex_wreg      = 5'($urandom_range(0, 3));
                exmem_branch   = ($urandom_range(0, 4) == 0);
                exmem_zero     = 1'($urandom_range(0, 1));
                exmem_memread  = ($urandom_range(0, 5) == 0);
                exmem_memwrite = ($urandom_range(0, 7) == 0);
                mem_ready      = ($urandom_range(0, 9) < thr);
                cycle("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
